// File: rtl/fetch_receive_intr_pkg.sv
// Shared definitions for the fetch-receive stage.
// Contents:
//   fr_state_e  - fetch-receive FSM state encoding (RUN / HOLD / SQUASH)
//   NOP_INSTR   - bubble encoding (addi x0,x0,0), also used by decode
package fetch_receive_intr_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } fr_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_receive_intr.sv
// Fetch-receive stage: pairs each i-memory response with the PC that produced it
// and hands {instruction, PC, valid} to decode. Holds the stalled instruction
// across decode stalls and discards wrong-path responses after a redirect.
// Ports:
//   clock        in   clock
//   reset        in   synchronous, active-high reset
//   issue_PC     in   PC presented to i-mem this cycle
//   i_mem_data   in   read data for the address issued the previous cycle
//   i_mem_valid  in   i_mem_data is valid
//   stall        in   decode cannot accept this cycle
//   flush        in   branch/trap redirect
//   instruction  out  instruction to decode
//   inst_PC      out  PC of instruction
//   inst_valid   out  instruction is real (0 = bubble)
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | live response from i-mem, tagged with the previous issue PC
// HOLD   | decode stalled; replay the captured instruction
// SQUASH | wrong-path responses after a flush are replaced by bubbles
module fetch_receive_intr
  import fetch_receive_intr_pkg::*;
#(
  parameter int                      CORE          = 0,
  parameter int                      ADDRESS_BITS  = 32,
  parameter int                      DATA_WIDTH    = 32,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC      = '0,
  parameter logic [DATA_WIDTH-1:0]   NOP           = DATA_WIDTH'(NOP_INSTR),
  parameter int                      SQUASH_CYCLES = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ADDRESS_BITS-1:0] issue_PC,
  input  logic [DATA_WIDTH-1:0]   i_mem_data,
  input  logic                    i_mem_valid,
  input  logic                    stall,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   instruction,
  output logic [ADDRESS_BITS-1:0] inst_PC,
  output logic                    inst_valid
);

  if (CORE < 0 || SQUASH_CYCLES < 1 || SQUASH_CYCLES > 15) begin : g_param_check
    $error("fetch_receive_intr: CORE must be >= 0 and SQUASH_CYCLES in 1..15");
  end

  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

  fr_state_e               state, state_next;
  logic [3:0]              sq_cnt, sq_cnt_next;
  logic [ADDRESS_BITS-1:0] pc_q;
  logic [DATA_WIDTH-1:0]   hold_inst;
  logic [ADDRESS_BITS-1:0] hold_PC;
  logic                    hold_valid;
  logic                    capture;
  logic [DATA_WIDTH-1:0]   live_inst;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      hold_inst  <= NOP;
      hold_PC    <= RESET_PC;
      hold_valid <= 1'b0;
      sq_cnt     <= 4'd0;
    end else begin
      state  <= state_next;
      pc_q   <= issue_PC;
      sq_cnt <= sq_cnt_next;
      if (capture) begin
        hold_inst  <= live_inst;
        hold_PC    <= pc_q;
        hold_valid <= i_mem_valid;
      end
    end
  end

  assign live_inst = i_mem_valid ? i_mem_data : NOP;

  always_comb begin
    state_next  = state;
    sq_cnt_next = sq_cnt;
    capture     = 1'b0;
    instruction = live_inst;
    inst_PC     = pc_q;
    inst_valid  = i_mem_valid;

    case (state)
      RUN: begin
        if (stall) begin
          state_next = HOLD;
          capture    = 1'b1;
        end
      end
      HOLD: begin
        instruction = hold_inst;
        inst_PC     = hold_PC;
        inst_valid  = hold_valid;
        if (!stall) state_next = RUN;
      end
      SQUASH: begin
        // stall is irrelevant here: a bubble needs no replay
        instruction = NOP;
        inst_valid  = 1'b0;
        sq_cnt_next = sq_cnt - 4'd1;
        if (sq_cnt <= 4'd1) state_next = RUN;
      end
      default: state_next = RUN;
    endcase

    // A redirect overrides both stall handling and an in-progress squash.
    if (flush) begin
      state_next  = SQUASH;
      sq_cnt_next = SQ_LOAD;
      capture     = 1'b0;
    end

    if (reset) begin
      instruction = NOP;
      inst_PC     = RESET_PC;
      inst_valid  = 1'b0;
    end
  end

endmodule
